// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Optional macro UART_TX_ARB_HEX_EN adds req_hex: granted bytes go out as two uppercase ASCII hex chars.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 8,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
`ifdef UART_TX_ARB_HEX_EN
    input  logic [NUM_REQ-1:0]              req_hex,
`endif
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
    input  logic                            uart_tx_busy,
    output logic [ID_W-1:0]                 grant_id,
    output logic                            idle
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                    state_r, state_s;
    logic [ID_W-1:0]           rr_ptr_r, rr_ptr_s;
    logic [ID_W-1:0]           grant_id_r, grant_id_s;
    logic [NUM_REQ-1:0]        ready_r, ready_s;
    logic                      tx_en_r, tx_en_s;
    logic [PAYLOAD_BITS-1:0]   tx_data_r, tx_data_s;
    logic                      idle_r, idle_s;
    logic                      any_s;
    logic [ID_W-1:0]           win_s;
    logic [PAYLOAD_BITS-1:0]   win_byte_s;

`ifdef UART_TX_ARB_HEX_EN
    logic                      hex_r, hex_s;
    logic                      nib_r, nib_s;
    logic [3:0]                lo_nib_r, lo_nib_s;

    function automatic logic [PAYLOAD_BITS-1:0] hex_char(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = 8'h30 + {4'h0, nib};
        end else begin
            c = 8'h37 + {4'h0, nib};
        end
        return PAYLOAD_BITS'(c);
    endfunction
`endif

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        int idx;
        any_s = 1'b0;
        win_s = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(rr_ptr_r) + off) % NUM_REQ;
            if (!any_s && req_valid[idx]) begin
                any_s = 1'b1;
                win_s = ID_W'(idx);
            end else begin
                any_s = any_s;
            end
        end
        win_byte_s = req_data[int'(win_s)*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    // Next-state and next-output logic for the grant/start/drain sequence.
    always_comb begin
        state_s    = state_r;
        rr_ptr_s   = rr_ptr_r;
        grant_id_s = grant_id_r;
        ready_s    = '0;
        tx_en_s    = tx_en_r;
        tx_data_s  = tx_data_r;
        idle_s     = idle_r;
`ifdef UART_TX_ARB_HEX_EN
        hex_s      = hex_r;
        nib_s      = nib_r;
        lo_nib_s   = lo_nib_r;
`endif
        case (state_r)
            IDLE: begin
                if (any_s && !uart_tx_busy) begin
                    state_s        = START;
                    grant_id_s     = win_s;
                    ready_s[win_s] = 1'b1;
                    rr_ptr_s       = ID_W'((int'(win_s) + 1) % NUM_REQ);
                    tx_en_s        = 1'b1;
                    idle_s         = 1'b0;
`ifdef UART_TX_ARB_HEX_EN
                    hex_s          = req_hex[win_s];
                    nib_s          = 1'b0;
                    lo_nib_s       = win_byte_s[3:0];
                    tx_data_s      = req_hex[win_s] ? hex_char(win_byte_s[7:4]) : win_byte_s;
`else
                    tx_data_s      = win_byte_s;
`endif
                end else begin
                    idle_s = 1'b1;
                end
            end
            START: begin
                if (uart_tx_busy) begin
                    tx_en_s = 1'b0;
                    state_s = DRAIN;
                end else begin
                    tx_en_s = 1'b1;
                end
            end
            DRAIN: begin
                tx_en_s = 1'b0;
                if (!uart_tx_busy) begin
`ifdef UART_TX_ARB_HEX_EN
                    // Low nibble of a hex transfer reuses START/DRAIN without passing IDLE.
                    if (hex_r && !nib_r) begin
                        nib_s     = 1'b1;
                        tx_data_s = hex_char(lo_nib_r);
                        tx_en_s   = 1'b1;
                        state_s   = START;
                    end else begin
                        state_s = IDLE;
                        idle_s  = 1'b1;
                    end
`else
                    state_s = IDLE;
                    idle_s  = 1'b1;
`endif
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
                tx_en_s = 1'b0;
                idle_s  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            rr_ptr_r   <= '0;
            grant_id_r <= '0;
            ready_r    <= '0;
            tx_en_r    <= 1'b0;
            tx_data_r  <= '0;
            idle_r     <= 1'b1;
`ifdef UART_TX_ARB_HEX_EN
            hex_r      <= 1'b0;
            nib_r      <= 1'b0;
            lo_nib_r   <= 4'h0;
`endif
        end else begin
            state_r    <= state_s;
            rr_ptr_r   <= rr_ptr_s;
            grant_id_r <= grant_id_s;
            ready_r    <= ready_s;
            tx_en_r    <= tx_en_s;
            tx_data_r  <= tx_data_s;
            idle_r     <= idle_s;
`ifdef UART_TX_ARB_HEX_EN
            hex_r      <= hex_s;
            nib_r      <= nib_s;
            lo_nib_r   <= lo_nib_s;
`endif
        end
    end

    assign req_ready    = ready_r;
    assign uart_tx_en   = tx_en_r;
    assign uart_tx_data = tx_data_r;
    assign grant_id     = grant_id_r;
    assign idle         = idle_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a transfer-level model.
// Build with UART_TX_ARB_HEX_EN defined to also exercise the hex feature.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic [N-1:0]     req_valid;
    logic [7:0]       pdata [N];
    logic [N*8-1:0]   req_data;
    logic [N-1:0]     req_hex;
    logic [N-1:0]     req_ready;
    logic             uart_tx_en;
    logic [7:0]       uart_tx_data;
    logic             uart_tx_busy;
    logic [1:0]       grant_id;
    logic             idle;
    logic             ext_busy;
    logic             mbusy;
    int               mcnt;
    int               busy_len;
    logic             busy_rand;
    logic [7:0]       cap_q [$];

    int errors = 0;
    int checks = 0;

    // Reference model state (transfer level).
    logic             m_active, m_seen;
    int               rr_m;
    logic [7:0]       m_cur;
    int               m_gid;
    logic [7:0]       chars [$];
    int               mode;
    int               dut_cnt [N];
    int               issued [N];
    int               dut_order [$];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) req_data[i*8 +: 8] = pdata[i];
    end

    assign uart_tx_busy = mbusy | ext_busy;

    uart_tx_arbiter #(.NUM_REQ(N), .PAYLOAD_BITS(8)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_data     (req_data),
`ifdef UART_TX_ARB_HEX_EN
        .req_hex      (req_hex),
`endif
        .req_ready    (req_ready),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .grant_id     (grant_id),
        .idle         (idle)
    );

    // uart_tx stand-in: accepts a byte when enabled and idle, busy from the next cycle.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mbusy <= 1'b0;
            mcnt  <= 0;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) mbusy <= 1'b0;
        end else if (uart_tx_en && !uart_tx_busy) begin
            cap_q.push_back(uart_tx_data);
            mbusy <= 1'b1;
            mcnt  <= busy_rand ? int'($urandom_range(1, 8)) : busy_len;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] asc(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    task automatic step();
        logic [N-1:0] v_p;
        logic [N-1:0] h_p;
        logic         busy_p, rst_p;
        logic [7:0]   d_p [N];
        logic [N-1:0] exp_ready;
        int           w;
        @(negedge clk);
        v_p = req_valid; h_p = req_hex; busy_p = uart_tx_busy; rst_p = resetn;
        for (int i = 0; i < N; i++) d_p[i] = pdata[i];
        @(posedge clk);
        #1;
        exp_ready = '0;
        if (!rst_p) begin
            m_active = 1'b0; m_seen = 1'b0; rr_m = 0; m_cur = 8'h00; m_gid = 0;
            chars.delete();
        end else if (!m_active) begin
            if (!busy_p && v_p != '0) begin
                w = rr_pick(v_p, rr_m);
                exp_ready[w] = 1'b1;
                m_gid = w;
                rr_m = (w + 1) % N;
                m_active = 1'b1;
                m_seen = 1'b0;
`ifdef UART_TX_ARB_HEX_EN
                if (h_p[w]) begin
                    m_cur = asc(d_p[w][7:4]);
                    chars.push_back(asc(d_p[w][3:0]));
                end else m_cur = d_p[w];
`else
                m_cur = d_p[w];
`endif
            end
        end else if (!m_seen) begin
            if (busy_p) m_seen = 1'b1;
        end else if (!busy_p) begin
            if (chars.size() > 0) begin
                m_cur = chars.pop_front();
                m_seen = 1'b0;
            end else m_active = 1'b0;
        end
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("grant_id", 32'(grant_id), 32'(m_gid));
        check_eq("idle", 32'(idle), 32'(!m_active));
        check_eq("uart_tx_en", 32'(uart_tx_en), 32'(m_active && !m_seen));
        check_eq("uart_tx_data", 32'(uart_tx_data), 32'(m_cur));
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                dut_cnt[i]++;
                dut_order.push_back(i);
                if (mode != 0) req_valid[i] = 1'b0;
            end
        end
        if (mode == 2) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    pdata[i] = 8'($urandom);
                    req_hex[i] = 1'($urandom_range(0, 1));
                    issued[i]++;
                end
            end
            ext_busy = ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_active || req_valid != '0) && n < budget) begin
            step();
            n++;
        end
        check_eq("wait_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    initial begin
        int base, n, pulses;
        int snap [N];
        resetn = 1'b0; req_valid = '0; req_hex = '0; ext_busy = 1'b0;
        busy_len = 20; busy_rand = 1'b0; mode = 1;
        m_active = 1'b0; m_seen = 1'b0; rr_m = 0; m_cur = 8'h00; m_gid = 0;
        for (int i = 0; i < N; i++) begin pdata[i] = 8'h00; dut_cnt[i] = 0; issued[i] = 0; end
        step(); step();
        resetn = 1'b1;

        // Single request: one-cycle latency to ready and enable.
        cap_q.delete();
        req_valid = 4'b0001; pdata[0] = 8'h41;
        step();
        check_eq("single_ready", 32'(req_ready), 32'h1);
        check_eq("single_en", 32'(uart_tx_en), 32'h1);
        wait_idle(100);
        check_eq("single_cap_n", 32'(cap_q.size()), 32'd1);
        if (cap_q.size() > 0) check_eq("single_cap", 32'(cap_q[0]), 32'h41);

        // Busy at request: no grant until busy clears, then grant next edge.
        ext_busy = 1'b1; req_valid = 4'b0010; pdata[1] = 8'h55; pulses = 0;
        for (int k = 0; k < 5; k++) begin step(); if (req_ready != '0) pulses++; end
        check_eq("busy_no_ready", 32'(pulses), 32'd0);
        ext_busy = 1'b0;
        step();
        check_eq("busy_release_grant", 32'(req_ready), 32'h2);
        wait_idle(100);

        // Late arrival: requester 1 rises during requester 0's START.
        base = dut_order.size();
        req_valid = 4'b0001; pdata[0] = 8'h30; n = 0;
        while (req_ready[0] !== 1'b1 && n < 20) begin step(); n++; end
        req_valid[1] = 1'b1; pdata[1] = 8'h31;
        wait_idle(200);
        check_eq("late_n", 32'(dut_order.size() - base), 32'd2);
        if (dut_order.size() >= base + 2) begin
            check_eq("late_first", 32'(dut_order[base]), 32'd0);
            check_eq("late_second", 32'(dut_order[base+1]), 32'd1);
        end

        // Contention from a fresh pointer: order 0,1,2,3,0.
        do_reset();
        mode = 0;
        for (int i = 0; i < N; i++) pdata[i] = 8'h30 + 8'(i);
        base = dut_order.size(); req_valid = 4'b1111; n = 0;
        while (dut_order.size() < base + 5 && n < 300) begin step(); n++; end
        req_valid = '0;
        mode = 1;
        wait_idle(100);
        check_eq("cont_n", 32'(dut_order.size() - base), 32'd5);
        for (int k = 0; k < 5; k++)
            if (dut_order.size() > base + k) check_eq("cont_order", 32'(dut_order[base+k]), 32'(k % N));

        // Mid-stream reset during DRAIN.
        mode = 0; req_valid = 4'b1111; n = 0;
        while (!(m_active && m_seen) && n < 100) begin step(); n++; end
        resetn = 1'b0;
        #1;
        check_eq("rst_en", 32'(uart_tx_en), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_idle", 32'(idle), 32'd1);
        check_eq("rst_gid", 32'(grant_id), 32'd0);
        step();
        resetn = 1'b1;
        step();
        check_eq("rst_next_grant", 32'(req_ready), 32'h1);
        req_valid = '0;
        mode = 1;
        wait_idle(100);

`ifdef UART_TX_ARB_HEX_EN
        // Hex mode: 8'h3A goes out as '3','A' with a single ready.
        cap_q.delete();
        pulses = dut_order.size();
        req_valid = 4'b0001; req_hex = 4'b0001; pdata[0] = 8'h3A;
        wait_idle(200);
        req_hex = '0;
        check_eq("hex_ready_n", 32'(dut_order.size() - pulses), 32'd1);
        check_eq("hex_cap_n", 32'(cap_q.size()), 32'd2);
        if (cap_q.size() >= 2) begin
            check_eq("hex_cap0", 32'(cap_q[0]), 32'h33);
            check_eq("hex_cap1", 32'(cap_q[1]), 32'h41);
        end
`endif

        // Randomized traffic with random busy lengths and external busy.
        busy_rand = 1'b1;
        for (int i = 0; i < N; i++) snap[i] = dut_cnt[i];
        mode = 2;
        for (int k = 0; k < 800; k++) step();
        mode = 1; ext_busy = 1'b0;
        wait_idle(600);
        for (int i = 0; i < N; i++)
            check_eq("rand_served", 32'(dut_cnt[i] - snap[i]), 32'(issued[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
